// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch-queue entry layout and field slices.
package pipe_pkg;

   localparam int FQ_DATA_W = 64;
   localparam int PC_HI     = 63;
   localparam int PC_LO     = 32;
   localparam int INST_HI   = 31;
   localparam int INST_LO   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, one asynchronous read port,
// synchronous clear.
module fq_storage #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between IF3 and ID; supports full cancel and a mispredict
// flush that can retain the head entry (the delay slot).
module fetch_queue
   import pipe_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = FQ_DATA_W,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_allow,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_allow,
   input  logic              cancel,
   input  logic              flush,
   input  logic              keep_head,
   output logic [PTR_W:0]    count
);

   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   cnt;
   logic             push;
   logic             pop;
   logic             keep;
   logic             wr_en;

   assign out_valid = (cnt != '0);
   assign in_allow  = (cnt != CNT_FULL) | out_allow;
   assign push      = in_valid & in_allow;
   assign pop       = out_valid & out_allow;
   // Delay slot survives only if it is present and ID is not taking it now.
   assign keep      = flush & keep_head & out_valid & ~out_allow;
   assign wr_en     = push & ~cancel & ~flush;
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (cancel) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (keep) begin
         wr_ptr <= rd_ptr + 1'b1;
         cnt    <= CNT_ONE;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   fq_storage #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_storage (
      .clk   (clk),
      .clear (~resetn),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   import pipe_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_allow;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_allow;
   logic        cancel;
   logic        flush;
   logic        keep_head;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_allow  (in_allow),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_allow (out_allow),
      .cancel    (cancel),
      .flush     (flush),
      .keep_head (keep_head),
      .count     (count)
   );

   function automatic logic [63:0] mk(input logic [31:0] pc);
      fq_entry_t e;
      e.pc   = pc;
      e.inst = 32'h2401_0000 | {16'h0, pc[15:0]};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check outputs against the model at negedge, then
   // advance the model by what the DUT commits at the next posedge.
   task automatic cyc(input logic iv, input logic [63:0] d, input logic oa,
                      input logic cn = 1'b0, input logic fl = 1'b0, input logic kh = 1'b0);
      logic do_pop;
      logic do_push;
      logic [63:0] head;
      in_valid  = iv;
      in_data   = d;
      out_allow = oa;
      cancel    = cn;
      flush     = fl;
      keep_head = kh;
      @(negedge clk);
      chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
      chk("count", {61'b0, count}, 64'(q.size()));
      chk("in_allow", {63'b0, in_allow}, {63'b0, (q.size() < DEPTH) || oa});
      do_pop  = (q.size() != 0) && oa;
      do_push = iv && ((q.size() < DEPTH) || oa);
      if (q.size() != 0) chk(do_pop ? "pop_data" : "head_data", out_data, q[0]);
      if (cn) begin
         q.delete();
      end else if (fl && kh && q.size() != 0 && !oa) begin
         head = q[0];
         q.delete();
         q.push_back(head);
      end else if (fl) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_allow = 1'b0;
      cancel    = 1'b0;
      flush     = 1'b0;
      keep_head = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      q.delete();
      chk("rst_count", {61'b0, count}, 64'd0);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_in_allow", {63'b0, in_allow}, 64'd1);
   endtask

   initial begin
      int pcn;
      do_reset();

      // 1: single entry, one-cycle latency, then pop
      cyc(1'b1, 64'h00000000_24010001, 1'b0);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // 2: fill, full back-pressure, push+pop while full, drain in order
      for (int i = 0; i < 4; i++) cyc(1'b1, mk(32'(4 * i)), 1'b0);
      cyc(1'b1, mk(32'h99), 1'b0);
      cyc(1'b1, mk(32'h10), 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // 3: flush keeping stalled head, concurrent push dropped
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h20 + 32'(4 * i)), 1'b0);
      cyc(1'b1, mk(32'h2C), 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // 4: flush with keep_head while head pops -> empty
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h20 + 32'(4 * i)), 1'b0);
      cyc(1'b1, mk(32'h2C), 1'b1, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // keep_head alone has no effect
      cyc(1'b1, mk(32'h40), 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, mk(32'h44), 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // 5: full queue, cancel+flush+push together, then a lone push
      for (int i = 0; i < 4; i++) cyc(1'b1, mk(32'h60 + 32'(4 * i)), 1'b0);
      cyc(1'b1, mk(32'h70), 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, mk(32'h80), 1'b0);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // 6: random traffic with pointer wrap, then reset mid-operation
      pcn = 0;
      for (int i = 0; i < 20; i++) begin
         cyc($urandom_range(3) != 0, mk(32'h100 + 32'(4 * pcn)), 1'($urandom_range(1)));
         pcn++;
      end
      cyc(1'b1, mk(32'h200), 1'b0);
      do_reset();
      cyc(1'b0, '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
